// File: rtl/centroid_tracker_if.sv
// Pixel-stream / object-result bundle between the detection stage, the
// centroid tracker and the overlay stage.
//   master : detection side, drives the scan position, mask and frame marker
//   slave  : centroid tracker, consumes pixels and returns the object centre
interface centroid_tracker_if #(
  parameter int DISP_WIDTH = 11
);
  logic                  enable;
  logic                  mask;
  logic [DISP_WIDTH-1:0] x_pos;
  logic [DISP_WIDTH-1:0] y_pos;
  logic                  frame_done;
  logic [DISP_WIDTH-1:0] x_obj;
  logic [DISP_WIDTH-1:0] y_obj;
  logic                  obj_valid;
  logic                  update;
  logic                  overrun;

  modport master (
    output enable, mask, x_pos, y_pos, frame_done,
    input  x_obj, y_obj, obj_valid, update, overrun
  );

  modport slave (
    input  enable, mask, x_pos, y_pos, frame_done,
    output x_obj, y_obj, obj_valid, update, overrun
  );
endinterface

// File: rtl/centroid_tracker.sv
// centroid_tracker: per-frame object centre locator.
// Sums the coordinates of every masked pixel over a frame, then at frame end
// runs two parallel restoring dividers (one quotient bit per cycle) to obtain
// the mean column/row, which is held on x_obj/y_obj for the overlay stage.
// Optional build macro CENTROID_HOLD_EN: when a frame has fewer than
// MIN_COUNT mask pixels, x_obj/y_obj keep their previous values instead of
// taking the new (possibly noisy) quotients.
module centroid_tracker #(
  parameter int DISP_WIDTH = 11,
  parameter int CNT_WIDTH  = 22,
  parameter int ACC_WIDTH  = 33,
  parameter int MIN_COUNT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  centroid_tracker_if.slave  bus
);

  localparam int BCW = $clog2(ACC_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(ACC_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_UPDATE
  } state_t;

  state_t                state_q;

  // frame accumulators
  logic [ACC_WIDTH-1:0]  sum_x_q, sum_y_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [ACC_WIDTH-1:0]  sum_x_d, sum_y_d;
  logic [CNT_WIDTH-1:0]  count_d;
  logic                  pix_hit;

  // divider state: quotient registers start out holding the dividend and
  // shift it out MSB-first while quotient bits shift in at the bottom
  logic [CNT_WIDTH-1:0]  div_q;
  logic [CNT_WIDTH-1:0]  rem_x_q, rem_y_q;
  logic [ACC_WIDTH-1:0]  quo_x_q, quo_y_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [CNT_WIDTH:0]    trial_x, trial_y;
  logic                  ge_x, ge_y;
  logic [CNT_WIDTH-1:0]  rem_x_d, rem_y_d;
  logic [ACC_WIDTH-1:0]  quo_x_d, quo_y_d;
  logic                  meets_min;

  // registered outputs
  logic [DISP_WIDTH-1:0] x_obj_q, y_obj_q;
  logic                  obj_valid_q, update_q, overrun_q;

  // Accumulator next values; once the counter saturates the frame is frozen
  // so sums and count stay consistent with each other.
  always_comb begin
    pix_hit = bus.enable & bus.mask & ~(&count_q);
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    count_d = count_q;
    if (pix_hit) begin
      sum_x_d = sum_x_q + ACC_WIDTH'(bus.x_pos);
      sum_y_d = sum_y_q + ACC_WIDTH'(bus.y_pos);
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // One restoring-division step for both coordinates. The partial remainder
  // is always below the divisor, so the difference fits in CNT_WIDTH bits.
  always_comb begin
    trial_x = {rem_x_q, quo_x_q[ACC_WIDTH-1]};
    trial_y = {rem_y_q, quo_y_q[ACC_WIDTH-1]};
    ge_x    = (trial_x >= {1'b0, div_q});
    ge_y    = (trial_y >= {1'b0, div_q});
    rem_x_d = ge_x ? (trial_x[CNT_WIDTH-1:0] - div_q) : trial_x[CNT_WIDTH-1:0];
    rem_y_d = ge_y ? (trial_y[CNT_WIDTH-1:0] - div_q) : trial_y[CNT_WIDTH-1:0];
    quo_x_d = {quo_x_q[ACC_WIDTH-2:0], ge_x};
    quo_y_d = {quo_y_q[ACC_WIDTH-2:0], ge_y};
    meets_min = (div_q >= CNT_WIDTH'(MIN_COUNT));
  end

  // Accumulation, frame snapshot, divider sequencing and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      count_q     <= '0;
      div_q       <= '0;
      rem_x_q     <= '0;
      rem_y_q     <= '0;
      quo_x_q     <= '0;
      quo_y_q     <= '0;
      bit_cnt_q   <= '0;
      x_obj_q     <= '0;
      y_obj_q     <= '0;
      obj_valid_q <= 1'b0;
      update_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      update_q  <= 1'b0;
      overrun_q <= 1'b0;
      sum_x_q   <= sum_x_d;
      sum_y_q   <= sum_y_d;
      count_q   <= count_d;

      case (state_q)
        S_DIV: begin
          rem_x_q   <= rem_x_d;
          rem_y_q   <= rem_y_d;
          quo_x_q   <= quo_x_d;
          quo_y_q   <= quo_y_d;
          bit_cnt_q <= bit_cnt_q + BCW'(1);
          if (bit_cnt_q == LAST_BIT) state_q <= S_UPDATE;
        end
        S_UPDATE: begin
`ifdef CENTROID_HOLD_EN
          if (meets_min) begin
            x_obj_q <= quo_x_q[DISP_WIDTH-1:0];
            y_obj_q <= quo_y_q[DISP_WIDTH-1:0];
          end
`else
          x_obj_q <= quo_x_q[DISP_WIDTH-1:0];
          y_obj_q <= quo_y_q[DISP_WIDTH-1:0];
`endif
          obj_valid_q <= meets_min;
          update_q    <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: ;
      endcase

      // Frame end always starts the next frame clean; the result is only
      // taken when the divider is free, otherwise the frame is dropped.
      if (bus.frame_done) begin
        sum_x_q <= '0;
        sum_y_q <= '0;
        count_q <= '0;
        if (state_q == S_IDLE) begin
          // with zero pixels the sums are zero too, so the quotients are 0
          div_q     <= count_d;
          quo_x_q   <= sum_x_d;
          quo_y_q   <= sum_y_d;
          rem_x_q   <= '0;
          rem_y_q   <= '0;
          bit_cnt_q <= '0;
          state_q   <= (count_d != '0) ? S_DIV : S_UPDATE;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign bus.x_obj     = x_obj_q;
  assign bus.y_obj     = y_obj_q;
  assign bus.obj_valid = obj_valid_q;
  assign bus.update    = update_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Bench for centroid_tracker: directed frames from the test plan plus
// randomized frames, checked against a frame-level arithmetic model.
module tb_centroid_tracker;

  localparam int DW   = 11;
  localparam int ACC  = 33;
  localparam int MINC = 16;

  logic clk = 1'b0;
  logic reset;
  int   edge_cnt = 0;
  int   upd_count = 0;
  int   ovr_count = 0;

  centroid_tracker_if #(.DISP_WIDTH(DW)) bus ();

  centroid_tracker #(
    .DISP_WIDTH(DW), .CNT_WIDTH(22), .ACC_WIDTH(ACC), .MIN_COUNT(MINC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (bus.update === 1'b1)  upd_count <= upd_count + 1;
    if (bus.overrun === 1'b1) ovr_count <= ovr_count + 1;
  end

  // reference model state
  longint msx, msy;
  int     mn;
  int     busy_until = 0;
  int     exp_x = 0, exp_y = 0, exp_v = 0;
  int     exp_upd = 0, exp_ovr = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.enable     = 1'b0;
    bus.mask       = 1'b0;
    bus.x_pos      = '0;
    bus.y_pos      = '0;
    bus.frame_done = 1'b0;
  endtask

  // Drive one pixel for one clock and advance the model.
  task automatic drive(input bit en, input bit m, input int x, input int y, input bit fd);
    int e;
    int nx, ny;
    bus.enable     = en;
    bus.mask       = m;
    bus.x_pos      = DW'(x);
    bus.y_pos      = DW'(y);
    bus.frame_done = fd;
    e = edge_cnt + 1;
    if (en && m) begin
      msx += x;
      msy += y;
      mn++;
    end
    if (fd) begin
      if (e > busy_until) begin
        if (mn == 0) begin
          nx = 0; ny = 0;
          busy_until = e + 1;
        end else begin
          nx = int'(msx / mn);
          ny = int'(msy / mn);
          busy_until = e + ACC + 1;
        end
        exp_v = (mn >= MINC) ? 1 : 0;
`ifdef CENTROID_HOLD_EN
        if (mn >= MINC) begin
          exp_x = nx; exp_y = ny;
        end
`else
        exp_x = nx; exp_y = ny;
`endif
        exp_upd++;
      end else begin
        exp_ovr++;
      end
      msx = 0; msy = 0; mn = 0;
    end
    tick();
  endtask

  // Wait for the update pulse and check its timing, the outputs and that
  // the pulse lasts exactly one cycle.
  task automatic wait_result(input string tag);
    int got;
    got = -1;
    for (int i = 0; i < 80 && got < 0; i++) begin
      tick();
      if (bus.update === 1'b1) got = edge_cnt;
    end
    chk({tag, "_edge"}, got, busy_until);
    chk({tag, "_x"}, 64'(bus.x_obj), exp_x);
    chk({tag, "_y"}, 64'(bus.y_obj), exp_y);
    chk({tag, "_valid"}, 64'(bus.obj_valid), exp_v);
    tick();
    chk({tag, "_pulse_end"}, 64'(bus.update), 0);
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    if (edge_cnt + 1 <= busy_until) exp_upd--;
    tick();
    reset = 1'b0;
    msx = 0; msy = 0; mn = 0;
    busy_until = 0;
    exp_x = 0; exp_y = 0; exp_v = 0;
  endtask

  // Filled rectangle of mask pixels, frame_done on the last one.
  task automatic send_rect(input int x0, input int y0, input int w, input int h);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        drive(1'b1, 1'b1, x0 + xx, y0 + yy, (yy == h - 1) && (xx == w - 1));
    set_idle();
  endtask

  initial begin
    msx = 0; msy = 0; mn = 0;
    set_idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // reset state held across an idle stretch
    repeat (50) tick();
    chk("rst_x", 64'(bus.x_obj), 0);
    chk("rst_y", 64'(bus.y_obj), 0);
    chk("rst_valid", 64'(bus.obj_valid), 0);
    chk("rst_upd_pulses", upd_count, 0);
    chk("rst_ovr_pulses", ovr_count, 0);

    // 20x20 square at x=100..119, y=200..219
    send_rect(100, 200, 20, 20);
    wait_result("square");

    // four pixels, below MIN_COUNT
    drive(1'b1, 1'b1, 10, 5, 1'b0);
    drive(1'b1, 1'b1, 11, 5, 1'b0);
    drive(1'b1, 1'b1, 10, 6, 1'b0);
    drive(1'b1, 1'b1, 11, 6, 1'b1);
    set_idle();
    wait_result("small");

    // empty frame; the frame_done pixel itself is masked but not enabled
    repeat (5) drive(1'b0, 1'b1, 700, 700, 1'b0);
    drive(1'b0, 1'b1, 500, 500, 1'b1);
    set_idle();
    wait_result("empty");

    // randomized windows with random mask density and enable gaps
    for (int f = 0; f < 8; f++) begin
      int w, h, x0, y0, dens;
      w    = $urandom_range(1, 12);
      h    = $urandom_range(1, 12);
      x0   = $urandom_range(0, 2047 - w);
      y0   = $urandom_range(0, 2047 - h);
      dens = $urandom_range(0, 100);
      for (int yy = 0; yy < h; yy++)
        for (int xx = 0; xx < w; xx++)
          drive($urandom_range(0, 7) != 0, $urandom_range(0, 99) < dens,
                x0 + xx, y0 + yy, (yy == h - 1) && (xx == w - 1));
      set_idle();
      wait_result($sformatf("rand%0d", f));
    end

    // second frame_done five cycles into the divide
    send_rect(40, 60, 5, 5);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1000 + i, 1500, 1'b0);
    drive(1'b1, 1'b1, 1010, 1500, 1'b1);
    set_idle();
    wait_result("ovr_first");
    chk("ovr_pulses", ovr_count, exp_ovr);
    repeat (40) tick();
    chk("ovr_discard_upds", upd_count, exp_upd);

    // the frame after the discarded one starts from clean accumulators
    send_rect(1200, 900, 6, 4);
    wait_result("after_ovr");

    // reset ten cycles into the divide aborts it
    send_rect(600, 700, 8, 8);
    repeat (10) tick();
    do_reset();
    chk("abort_x", 64'(bus.x_obj), 0);
    chk("abort_y", 64'(bus.y_obj), 0);
    chk("abort_valid", 64'(bus.obj_valid), 0);
    chk("abort_update", 64'(bus.update), 0);
    repeat (45) tick();
    chk("abort_no_update", upd_count, exp_upd);

    // full frame centred on (300,400)
    send_rect(298, 398, 5, 5);
    wait_result("post_abort");

    repeat (5) tick();
    chk("total_updates", upd_count, exp_upd);
    chk("total_overruns", ovr_count, exp_ovr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
